svc_rv_soc_run_ctrl: RTL and testbench
======================================

Name: svc_rv_soc_run_ctrl

Overview:
Run controller that sequences a BRAM/cache RISC-V SoC demo on an FPGA board. It holds the SoC in reset, then releases it for a run and monitors ebreak. It measures run length in cycles, enforces a watchdog timeout, and drives a status LED. It sits between the board top (clock, reset, button, LED) and the SoC instance, and replaces the ad-hoc ebreak latch.

Parameters:
RST_CYCLES, 16, cycles soc_rst_n is held low in RESET before release; must be >= 1
TIMEOUT_CYCLES, 1000000, max RUN cycles before FAULT; 0 disables watchdog
CNT_W, 32, width of cycle_count; must hold TIMEOUT_CYCLES
BLINK_W, 24, free-running blink counter width; LED toggles at bit BLINK_W-1
AUTO_START, 1, 1 = start one run automatically after rst deasserts

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  synchronous run request, level or pulse, sampled each cycle
ebreak  input  1  SoC halted on EBREAK
soc_rst_n  output  1  active-low reset to SoC, registered
running  output  1  state is RUN
done  output  1  state is DONE
timeout  output  1  state is FAULT
cycle_count  output  CNT_W  RUN cycles of current/last run
led  output  1  status LED

Behaviour:
- One clock; reset is asynchronous and active-high; all state clears on rst assertion regardless of clk.
- Reset values: state IDLE, soc_rst_n=0, running=0, done=0, timeout=0, cycle_count=0, led=0, auto_armed=AUTO_START, counters 0.
- All outputs are registered and reflect the current state (no combinational paths from inputs).
- States: IDLE, RESET, RUN, DONE, FAULT.
- IDLE: soc_rst_n=0.
  - Go to RESET if start, or if auto_armed. auto_armed clears on that transition, so auto-start happens once per rst.
- RESET: soc_rst_n=0; rst counter counts 0..RST_CYCLES-1, then go to RUN.
  - cycle_count clears to 0 on entry.
  - soc_rst_n goes high in the first RUN cycle, exactly RST_CYCLES cycles after RESET is entered.
- RUN: soc_rst_n=1, running=1; cycle_count += 1 every RUN cycle, including the cycle ebreak is sampled.
  - ebreak=1 -> DONE next cycle; cycle_count freezes at the incremented value. Example: ebreak in the first RUN cycle gives cycle_count=1.
  - If TIMEOUT_CYCLES != 0, cycle_count == TIMEOUT_CYCLES-1 and ebreak=0 -> FAULT; cycle_count becomes TIMEOUT_CYCLES.
  - ebreak and the timeout condition in the same cycle: ebreak wins (DONE).
  - start is ignored in RUN.
- DONE: done=1, led=1 solid, soc_rst_n stays 1 (core remains halted for inspection), cycle_count held.
  - start -> RESET (rerun).
- FAULT: timeout=1, soc_rst_n=0 (SoC quiesced), led = blink counter bit BLINK_W-1, cycle_count held.
  - start -> RESET.
- ebreak is ignored in every state except RUN (SoC outputs are undefined while in reset).
- led=0 in IDLE, RESET and RUN.
- Blink counter: free-running, wraps modulo 2^BLINK_W, runs in all states, clears only on rst.
- cycle_count saturates at all-ones if TIMEOUT_CYCLES=0; it never wraps.
- rst asserted mid-RUN: soc_rst_n drops immediately (async) and all outputs take reset values. auto_armed is reloaded, so a fresh auto-run follows deassertion when AUTO_START=1.
- start held high continuously: after DONE/FAULT it causes an immediate rerun (one cycle in DONE/FAULT, then RESET). This is intended for looped soak runs.

Decomposition:
- Package svc_rv_soc_run_ctrl_pkg:
  - state enum (IDLE, RESET, RUN, DONE, FAULT, 3-bit encoding)
  - localparam helper for the reset-counter width, $clog2(RST_CYCLES+1)
- Sub-module svc_led_blink (BLINK_W parameter; clk, rst, en -> blink): free-running counter with its MSB gated by en. Reusable by other demo tops.
- The FSM, reset counter and cycle/watchdog counter live in the top module.

Test Plan:
- AUTO_START=1, RST_CYCLES=4, ebreak pulsed on the 10th RUN cycle:
  - soc_rst_n low for exactly 4 cycles after rst deassert plus the IDLE cycle
  - running=1 for 10 cycles, then done=1, led=1, cycle_count=10, soc_rst_n stays 1
- AUTO_START=0:
  - no activity without start; soc_rst_n=0 indefinitely
  - a 1-cycle start pulse -> RESET next cycle, then RUN after RST_CYCLES
- TIMEOUT_CYCLES=20, ebreak never asserted:
  - FAULT after 20 RUN cycles, timeout=1, cycle_count=20, soc_rst_n=0
  - led toggles every 2^(BLINK_W-1) cycles (BLINK_W=4 -> toggles every 8 cycles)
- TIMEOUT_CYCLES=20, ebreak asserted on RUN cycle 20 (same cycle as timeout):
  - DONE, done=1, timeout=0, cycle_count=20
- ebreak held high during IDLE/RESET -> ignored; the first RUN cycle sees ebreak -> DONE, cycle_count=1.
- rst asserted mid-RUN (cycle 5, asynchronously between clk edges):
  - soc_rst_n=0, cycle_count=0, outputs at reset values immediately
  - after release with AUTO_START=1, a complete run with cycle_count matching the ebreak timing
- In DONE, pulse start:
  - rerun with soc_rst_n low for RST_CYCLES
  - cycle_count restarts from 0; second ebreak at RUN cycle 3 gives cycle_count=3

Source files
------------

// File: rtl/svc_rv_soc_run_ctrl_pkg.sv
// Shared types and helpers for the SoC run controller: FSM state encoding and
// the width of the hold-in-reset counter.
package svc_rv_soc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } run_state_e;

  // Bits needed to count 0..cycles; never below one bit.
  function automatic int rst_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/svc_led_blink.sv
// Free-running blink source: counter MSB gated by en. Counts in every state and
// clears only on rst, so the blink phase is stable relative to board reset.
module svc_led_blink #(
  parameter int BLINK_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic blink
);

  logic [BLINK_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + BLINK_W'(1);
  end

  assign blink = en & cnt[BLINK_W-1];

endmodule

// File: rtl/svc_rv_soc_run_ctrl.sv
// Run controller for the RISC-V SoC demo: holds the SoC in reset, releases it
// for a run, watches ebreak, counts run cycles and enforces a watchdog.
module svc_rv_soc_run_ctrl
  import svc_rv_soc_run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32,
  parameter int BLINK_W        = 24,
  parameter int AUTO_START     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ebreak,
  output logic             soc_rst_n,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic             led
);

  localparam int               RCW      = rst_cnt_width(RST_CYCLES);
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);

  // Saturating increment keeps the run length from wrapping when the
  // watchdog is disabled.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  run_state_e       state, state_next;
  logic [RCW-1:0]   rcnt, rcnt_next;
  logic [CNT_W-1:0] ccnt, ccnt_next;
  logic             armed, armed_next;
  logic             blink;

  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    ccnt_next  = ccnt;
    armed_next = armed;
    unique case (state)
      ST_IDLE: begin
        if (start || armed) begin
          state_next = ST_RESET;
          armed_next = 1'b0;
          rcnt_next  = '0;
          ccnt_next  = '0;
        end
      end
      ST_RESET: begin
        if (rcnt == RST_LAST) state_next = ST_RUN;
        else                  rcnt_next  = rcnt + RCW'(1);
      end
      ST_RUN: begin
        ccnt_next = sat_inc(ccnt);
        // ebreak takes priority over a watchdog expiry in the same cycle
        if (ebreak)                          state_next = ST_DONE;
        else if (WDOG_EN && ccnt == TO_LAST) state_next = ST_FAULT;
      end
      ST_DONE, ST_FAULT: begin
        if (start) begin
          state_next = ST_RESET;
          rcnt_next  = '0;
          ccnt_next  = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are flops loaded from the next state so they align with
  // the state register and carry no path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rcnt      <= '0;
      ccnt      <= '0;
      armed     <= (AUTO_START != 0);
      soc_rst_n <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      rcnt      <= rcnt_next;
      ccnt      <= ccnt_next;
      armed     <= armed_next;
      soc_rst_n <= (state_next == ST_RUN) || (state_next == ST_DONE);
      running   <= (state_next == ST_RUN);
      done      <= (state_next == ST_DONE);
      timeout   <= (state_next == ST_FAULT);
    end
  end

  svc_led_blink #(
    .BLINK_W(BLINK_W)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (timeout),
    .blink(blink)
  );

  assign cycle_count = ccnt;
  assign led         = done | blink;

endmodule

// File: tb/tb_svc_rv_soc_run_ctrl.sv
// Bench for svc_rv_soc_run_ctrl: an auto-start instance with a 20-cycle
// watchdog and a manual-start instance with the watchdog disabled.
module tb_svc_rv_soc_run_ctrl;

  localparam int RC   = 4;
  localparam int TO   = 20;
  localparam int CW   = 8;
  localparam int BW   = 4;
  localparam int RC_M = 2;
  localparam int CW_M = 6;
  localparam int SAT_M = (1 << CW_M) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, ebreak = 1'b0, start_m = 1'b0, ebreak_m = 1'b0;
  logic soc_rst_n, running, done, timeout, led;
  logic soc_rst_n_m, running_m, done_m, timeout_m, led_m;
  logic [CW-1:0]   cycle_count;
  logic [CW_M-1:0] cycle_count_m;
  logic [4:0] st, st_m;

  int chk = 0;
  int pass = 0;

  assign st   = {soc_rst_n, running, done, timeout, led};
  assign st_m = {soc_rst_n_m, running_m, done_m, timeout_m, led_m};

  always #5 clk = ~clk;

  svc_rv_soc_run_ctrl #(
    .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CW), .BLINK_W(BW), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ebreak(ebreak),
    .soc_rst_n(soc_rst_n), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .led(led)
  );

  svc_rv_soc_run_ctrl #(
    .RST_CYCLES(RC_M), .TIMEOUT_CYCLES(0), .CNT_W(CW_M), .BLINK_W(BW), .AUTO_START(0)
  ) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .ebreak(ebreak_m),
    .soc_rst_n(soc_rst_n_m), .running(running_m), .done(done_m), .timeout(timeout_m),
    .cycle_count(cycle_count_m), .led(led_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected run: RC cycles in reset, then RUN cycles showing 0,1,2,...;
  // ebreak on RUN cycle k ends in DONE with count k unless the watchdog
  // fires first (k > TO), which ends in FAULT with count TO.
  task automatic do_run(input int k, input bit eb_early, input int abort_at,
                        input bit hold, input string tag);
    int last;
    for (int i = 0; i < RC; i++) begin
      ebreak = eb_early;
      chk++;
      if (st !== 5'b00000 || cycle_count !== '0)
        $display("FAIL %s reset_phase c%0d: got st=%b cnt=%0d want st=00000 cnt=0",
                 tag, i, st, cycle_count);
      else pass++;
      step();
    end
    last = (k <= TO) ? k : TO;
    for (int j = 1; j <= last; j++) begin
      ebreak = (j == k);
      start  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      chk++;
      if (st !== 5'b11000 || cycle_count !== CW'(j - 1))
        $display("FAIL %s run_c%0d: got st=%b cnt=%0d want st=11000 cnt=%0d",
                 tag, j, st, cycle_count, j - 1);
      else pass++;
      if (j == abort_at) begin
        #3 rst = 1'b1;
        #1;
        ebreak = 1'b0;
        start  = 1'b0;
        chk++;
        if (st !== 5'b00000 || cycle_count !== '0)
          $display("FAIL %s async_rst: got st=%b cnt=%0d want st=00000 cnt=0",
                   tag, st, cycle_count);
        else pass++;
        return;
      end
      step();
    end
    ebreak = 1'b0;
    start  = hold;
    if (k <= TO) begin
      chk++;
      if (st !== 5'b10101 || cycle_count !== CW'(k))
        $display("FAIL %s done: got st=%b cnt=%0d want st=10101 cnt=%0d",
                 tag, st, cycle_count, k);
      else pass++;
    end else begin
      chk++;
      if (st[4:1] !== 4'b0001 || cycle_count !== CW'(TO))
        $display("FAIL %s fault: got st=%b cnt=%0d want st=0001x cnt=%0d",
                 tag, st, cycle_count, TO);
      else pass++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    chk++;
    if (st !== 5'b00000 || cycle_count !== '0 || st_m !== 5'b00000 || cycle_count_m !== '0)
      $display("FAIL reset_values: got st=%b cnt=%0d st_m=%b cnt_m=%0d want all 0",
               st, cycle_count, st_m, cycle_count_m);
    else pass++;
  endtask

  task automatic test_auto_run();
    #1 rst = 1'b0;
    chk++;
    if (st !== 5'b00000)
      $display("FAIL auto_idle: got st=%b want 00000", st);
    else pass++;
    step();
    do_run(10, 1'b0, 0, 1'b0, "auto");
    for (int i = 0; i < 3; i++) begin
      ebreak = 1'($urandom_range(0, 1));
      step();
      chk++;
      if (st !== 5'b10101 || cycle_count !== CW'(10))
        $display("FAIL done_hold c%0d: got st=%b cnt=%0d want st=10101 cnt=10",
                 i, st, cycle_count);
      else pass++;
    end
    ebreak = 1'b0;
  endtask

  task automatic test_rerun();
    pulse_start();
    do_run(3, 1'b0, 0, 1'b0, "rerun");
  endtask

  task automatic test_timeout_blink();
    logic prev;
    int toggles, t_last;
    pulse_start();
    do_run(25, 1'b0, 0, 1'b0, "wdog");
    prev = led;
    toggles = 0;
    t_last = -1;
    for (int i = 1; i <= 24; i++) begin
      ebreak = 1'($urandom_range(0, 1));
      step();
      chk++;
      if (st[4:1] !== 4'b0001 || cycle_count !== CW'(TO))
        $display("FAIL fault_hold c%0d: got st=%b cnt=%0d want st=0001x cnt=%0d",
                 i, st, cycle_count, TO);
      else pass++;
      if (led !== prev) begin
        toggles++;
        if (t_last >= 0) begin
          chk++;
          if (i - t_last != 8)
            $display("FAIL blink_period: got %0d want 8", i - t_last);
          else pass++;
        end
        t_last = i;
      end
      prev = led;
    end
    ebreak = 1'b0;
    chk++;
    if (toggles != 3)
      $display("FAIL blink_toggles: got %0d want 3", toggles);
    else pass++;
  endtask

  task automatic test_tie();
    pulse_start();
    do_run(TO, 1'b0, 0, 1'b0, "tie");
  endtask

  task automatic test_ebreak_early();
    ebreak = 1'b1;
    pulse_start();
    do_run(1, 1'b1, 0, 1'b0, "early");
  endtask

  task automatic test_async_reset();
    pulse_start();
    do_run(10, 1'b0, 5, 1'b0, "abort");
    @(posedge clk);
    #2 rst = 1'b0;
    chk++;
    if (st !== 5'b00000 || cycle_count !== '0)
      $display("FAIL post_abort_idle: got st=%b cnt=%0d want st=00000 cnt=0", st, cycle_count);
    else pass++;
    step();
    do_run($urandom_range(1, 19), 1'b0, 0, 1'b0, "post_abort");
  endtask

  task automatic test_random_runs();
    for (int n = 0; n < 6; n++) begin
      pulse_start();
      do_run($urandom_range(1, 26), 1'b0, 0, 1'b0, "rand");
    end
  endtask

  task automatic test_start_held();
    start = 1'b1;
    step();
    do_run(2, 1'b0, 0, 1'b1, "held1");
    step();
    do_run(4, 1'b0, 0, 1'b1, "held2");
    start = 1'b0;
    step();
    chk++;
    if (st !== 5'b10101 || cycle_count !== CW'(4))
      $display("FAIL held_release: got st=%b cnt=%0d want st=10101 cnt=4", st, cycle_count);
    else pass++;
  endtask

  task automatic test_manual();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk++;
      if (st_m !== 5'b00000 || cycle_count_m !== '0)
        $display("FAIL manual_idle c%0d: got st=%b cnt=%0d want st=00000 cnt=0",
                 i, st_m, cycle_count_m);
      else pass++;
    end
    start_m = 1'b1;
    step();
    start_m = 1'b0;
    for (int i = 0; i < RC_M; i++) begin
      chk++;
      if (st_m !== 5'b00000)
        $display("FAIL manual_reset c%0d: got st=%b want 00000", i, st_m);
      else pass++;
      step();
    end
    for (int j = 1; j <= 70; j++) begin
      ebreak_m = (j == 70);
      chk++;
      if (st_m !== 5'b11000 || cycle_count_m !== CW_M'((j - 1 < SAT_M) ? j - 1 : SAT_M))
        $display("FAIL manual_run c%0d: got st=%b cnt=%0d want st=11000 cnt=%0d",
                 j, st_m, cycle_count_m, (j - 1 < SAT_M) ? j - 1 : SAT_M);
      else pass++;
      step();
    end
    ebreak_m = 1'b0;
    chk++;
    if (st_m !== 5'b10101 || cycle_count_m !== CW_M'(SAT_M))
      $display("FAIL manual_sat_done: got st=%b cnt=%0d want st=10101 cnt=%0d",
               st_m, cycle_count_m, SAT_M);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_auto_run();
    test_rerun();
    test_timeout_blink();
    test_tie();
    test_ebreak_early();
    test_async_reset();
    test_random_runs();
    test_start_held();
    test_manual();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got no finish want finish before 200000");
    $fatal(1, "time limit");
  end

endmodule
